// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg -- shared definitions for the mux_rr channel multiplexer.
//
// Contents:
//   MODE_FIXED / MODE_RR : encodings of the mux_rr 'mode' input
//   idx_width()          : width of a channel index for a given channel count
//                          (never less than 1 bit)
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- grant selection for mux_rr.
//
// Fixed mode grants 'sel' when that channel requests; an out-of-range sel
// grants nothing. Round-robin mode searches upward from ptr+1, wrapping from
// CHANNELS-1 to 0, and grants the first requesting channel. The pointer moves
// to the granted index only when 'advance' (an input transfer) is high in
// round-robin mode.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-channel request (in_valid)
//   mode        : MODE_FIXED / MODE_RR
//   sel         : channel chosen in fixed mode
//   advance     : a transfer happens on this edge
//   grant       : one-hot grant (all zero when nothing granted)
//   grant_idx   : index of the granted channel
//   grant_any   : some channel is granted
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = idx_width(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            req,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel,
    input  logic                           advance,
    output logic [CHANNELS-1:0]            grant,
    output logic [idx_width(CHANNELS)-1:0] grant_idx,
    output logic                           grant_any
);

    localparam int IDX_W = idx_width(CHANNELS);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int c;
        c         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (mode == MODE_FIXED) begin
            // Only indices that exist can match, so sel >= CHANNELS grants nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            // Offsets 1..CHANNELS cover every channel once, the current
            // pointer holder last.
            for (int k = 1; k <= CHANNELS; k++) begin
                c = int'(ptr) + k;
                if (c >= CHANNELS) c = c - CHANNELS;
                if (!grant_any && req[c]) begin
                    grant[c]  = 1'b1;
                    grant_idx = IDX_W'(c);
                    grant_any = 1'b1;
                end
            end
        end
    end

    // Reset value CHANNELS-1 makes channel 0 the first round-robin winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(CHANNELS - 1);
        end else if (advance && mode == MODE_RR) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mux_rr.sv
// mux_rr -- N-channel to 1 multiplexer with fixed or round-robin selection
// and a registered valid/ready output.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high; a source holds valid and data stable until it
// sees ready. At most one in_ready bit is high, and only for the granted
// channel.
//
// Build option: define MUX_RR_SKID_EN to place a 2-entry skid buffer in
// front of out_data, so in_ready depends only on registered state. Without
// it a single output register is used and in_ready is gated by
// (!out_valid || out_ready). Ports and reset values are the same in both.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : per-channel handshake
//   in_data             : channel i at [i*WIDTH +: WIDTH]
//   mode                : MODE_FIXED (use sel) or MODE_RR
//   sel                 : fixed-mode channel (values >= CHANNELS grant nothing)
//   out_valid/out_ready : output handshake
//   out_data, out_chan  : held data and its source channel
module mux_rr
    import mux_rr_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = idx_width(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [CHANNELS*WIDTH-1:0]      in_data,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               sel,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [idx_width(CHANNELS)-1:0] out_chan
);

    localparam int IDX_W = idx_width(CHANNELS);

    logic [CHANNELS-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                can_accept;
    logic                xfer;
    logic [WIDTH-1:0]    mux_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .mode      (mode),
        .sel       (sel),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == IDX_W'(i)) mux_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    // rst_n in the gate keeps every in_ready low while reset is held.
    assign in_ready = (can_accept && rst_n) ? grant : '0;
    assign xfer     = grant_any && can_accept && rst_n;

`ifdef MUX_RR_SKID_EN

    logic [WIDTH-1:0] skid_data [2];
    logic [IDX_W-1:0] skid_chan [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             pop;

    // Space is judged from the registered fill level only; a drain on this
    // edge is not credited, which the second entry absorbs.
    assign can_accept = (count != 2'd2);
    assign pop        = (count != 2'd0) && out_ready;

    assign out_valid = (count != 2'd0);
    assign out_data  = skid_data[rd_ptr];
    assign out_chan  = skid_chan[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                skid_data[i] <= '0;
                skid_chan[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (xfer) begin
                skid_data[wr_ptr] <= mux_data;
                skid_chan[wr_ptr] <= grant_idx;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(xfer) - 2'(pop);
        end
    end

`else

    assign can_accept = !out_valid || out_ready;

    // A new transfer overwrites the register even while it is draining, so
    // out_valid stays high under continuous traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr -- self-checking bench for mux_rr (WIDTH=16, CHANNELS=4, sel
// widened to 3 bits so out-of-range fixed selections can be driven).
// The reference model keeps the output contents as a queue and the
// round-robin pointer as a plain integer; grants come from modulo search.
module tb_mux_rr;
    import mux_rr_pkg::*;

    localparam int W  = 16;
    localparam int CH = 4;
`ifdef MUX_RR_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [CH*W-1:0] in_data;
    logic            mode;
    logic [2:0]      sel;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_chan;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mux_rr #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .SEL_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    // ---------------- model / scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   chan_q[$];
    int           m_ptr;
    int           seen_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [CH-1:0] last_in_ready;
    logic [W-1:0]  last_out_data;
    logic [1:0]    last_out_chan;
    logic          last_out_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (mode == MODE_FIXED) begin
            if (int'(sel) < CH) begin
                if (in_valid[sel[1:0]]) return int'(sel);
            end
            return -1;
        end
        for (int k = 1; k <= CH; k++) begin
            if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
        end
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, return 1ns later so inputs can be changed safely.
    task automatic tick();
        int g;
        logic acc;
        logic [CH-1:0] er;
        @(negedge clk);
        g = model_grant();
        if (CAP == 1) acc = rst_n && (exp_q.size() == 0 || out_ready);
        else          acc = rst_n && (exp_q.size() < CAP);
        er = (g >= 0 && acc) ? CH'(1 << g) : '0;
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            check("out_chan", 32'(out_chan), 32'(chan_q[0]));
            seen_q.push_back(int'(out_chan));
        end
        last_in_ready  = in_ready;
        last_out_data  = out_data;
        last_out_chan  = out_chan;
        last_out_valid = out_valid;
        @(posedge clk);
        if (exp_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            void'(chan_q.pop_front());
        end
        if (g >= 0 && acc) begin
            exp_q.push_back(in_data[g*W +: W]);
            chan_q.push_back(2'(g));
            if (mode == MODE_RR) m_ptr = g;
        end
        #1;
    endtask

    // Called 1ns after a rising edge; asserts reset between edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        chan_q.delete();
        m_ptr = CH - 1;
    endtask

    task automatic release_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (CAP) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        mode      = MODE_FIXED;
        sel       = '0;
        out_ready = 1'b0;
        m_ptr     = CH - 1;
        #12;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_data", 32'(out_data), 32'd0);
        check("init_out_chan", 32'(out_chan), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        release_reset();
        tick();

        // Fixed mode, sel=2
        mode = MODE_FIXED; sel = 3'd2; in_valid = 4'hf; out_ready = 1'b1;
        in_data = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
        tick();
        check("fixed_in_ready", 32'(last_in_ready), 32'h4);
        tick();
        check("fixed_out_data", 32'(last_out_data), 32'h1234);
        check("fixed_out_chan", 32'(last_out_chan), 32'd2);
        drain();

        // Round-robin over all four channels
        seen_q.delete();
        mode = MODE_RR; in_valid = 4'hf;
        repeat (5) tick();
        in_valid = '0;
        tick();
        check("rr4_count", 32'(seen_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen_q.size(); i++)
            check("rr4_seq", 32'(seen_q[i]), 32'(i % 4));
        repeat (CAP) tick();

        // Round-robin with ch1 and ch3 only
        seen_q.delete();
        in_valid = 4'b1010;
        repeat (4) tick();
        in_valid = '0;
        tick();
        check("rr13_count", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_q.size(); i++)
            check("rr13_seq", 32'(seen_q[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        drain();

        // Back-pressure hold
        in_valid = 4'b0001; in_data[15:0] = 16'h9876;
        tick();
        out_ready = 1'b0; in_valid = 4'hf;
        repeat (3) begin
            tick();
            check("hold_out_data", 32'(last_out_data), 32'h9876);
`ifndef MUX_RR_SKID_EN
            check("hold_in_ready", 32'(last_in_ready), 32'd0);
`endif
        end
        out_ready = 1'b1;
        tick();
`ifndef MUX_RR_SKID_EN
        check("after_hold_grant", 32'(last_in_ready), 32'h2);
`endif
        drain();

        // Reset while holding 16'hAAAA
        mode = MODE_FIXED; sel = 3'd1; in_valid = 4'b0010;
        in_data[31:16] = 16'hAAAA;
        tick();
        out_ready = 1'b0; in_valid = '0;
        tick();
        check("pre_rst_data", 32'(last_out_data), 32'hAAAA);
        async_reset();
        tick();
        release_reset();
        mode = MODE_RR; in_valid = 4'hf; out_ready = 1'b1;
        tick();
        check("post_rst_grant", 32'(last_in_ready), 32'h1);
        drain();

        // Out-of-range fixed selection
        mode = MODE_FIXED; sel = 3'd5; in_valid = 4'hf;
        repeat (3) begin
            tick();
            check("sel5_in_ready", 32'(last_in_ready), 32'd0);
            check("sel5_out_valid", 32'(last_out_valid), 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            mode      = logic'($urandom_range(0, 1));
            sel       = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                    : 3'($urandom_range(0, 3));
            in_valid  = CH'($urandom_range(0, 15));
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                async_reset();
                tick();
                release_reset();
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
